// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc
// OPB slave that lets the PowerPC read a 32-bit value captured from the fabric.
// The slave decodes two words in its address window:
//   offset 0x0  DATA   : last value captured on user_valid (read-only from OPB)
//   offset 0x4  STATUS : [31:16] update count, [1] overflow, [0] new flag
// Other low address bits alias onto these two words.
//
// OPB transfer handshake: a transfer is requested while OPB_select is high
// and the address falls inside [C_BASEADDR, C_HIGHADDR]. The slave answers
// with exactly one Sl_xferAck cycle, one cycle after the request is sampled,
// then waits for OPB_select to drop before decoding another request. Read
// data is valid on Sl_DBus only in the Sl_xferAck cycle and is zero otherwise.
//
// Ports
//   OPB_Clk, OPB_Rst_n     clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW   OPB address, byte enables, write data, read flag
//   OPB_select, seqAddr    transfer active, sequential hint (ignored)
//   Sl_DBus, Sl_xferAck    read data, transfer acknowledge
//   Sl_errAck/retry/toutSup  tied to 0
//   user_data_in, user_valid  fabric value and its one-cycle capture strobe
//   dbg_state              current slave FSM state (IDLE=0, ACK=1, HOLD=2)
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [31:0]                 user_data_in,
  input  logic                        user_valid,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Window check as offset <= span avoids a constant-true compare when the
  // base address is zero.
  localparam logic [31:0] ADDR_SPAN = C_HIGHADDR - C_BASEADDR;

  state_t      state_q, state_d;
  logic [31:0] addr_off;
  logic        hit;

  // Attributes of the transfer being acknowledged, latched when it is decoded.
  logic        rnw_q;
  logic        stat_sel_q;
  logic        be3_q;
  logic        wbit1_q;

  logic [31:0] data_q;
  logic [15:0] count_q;
  logic        ovf_q;
  logic        new_q;

  logic        ack;
  logic        data_rd;
  logic        stat_clr;
  logic [31:0] rd_word;

  assign addr_off = OPB_ABus - C_BASEADDR;
  assign hit      = OPB_select && (addr_off <= ADDR_SPAN);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  if (!OPB_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rnw_q      <= 1'b0;
      stat_sel_q <= 1'b0;
      be3_q      <= 1'b0;
      wbit1_q    <= 1'b0;
    end else if (state_q == S_IDLE && hit) begin
      rnw_q      <= OPB_RNW;
      stat_sel_q <= OPB_ABus[C_OPB_AWIDTH-3];
      be3_q      <= OPB_BE[C_OPB_DWIDTH/8-1];
      wbit1_q    <= OPB_DBus[C_OPB_DWIDTH-2];
    end
  end

  assign ack      = (state_q == S_ACK);
  assign data_rd  = ack && rnw_q && !stat_sel_q;
  assign stat_clr = ack && !rnw_q && stat_sel_q && be3_q && wbit1_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q  <= 32'h0;
      count_q <= 16'h0;
      ovf_q   <= 1'b0;
      new_q   <= 1'b0;
    end else begin
      if (user_valid) begin
        data_q  <= user_data_in;
        count_q <= count_q + 16'd1;
      end
      // A capture in the same cycle as a DATA read keeps the flag set: the
      // reader saw the old value, so the new one is still unread.
      if (user_valid)   new_q <= 1'b1;
      else if (data_rd) new_q <= 1'b0;
      // Setting beats clearing so a capture over unread data is never lost.
      if (user_valid && new_q) ovf_q <= 1'b1;
      else if (stat_clr)       ovf_q <= 1'b0;
    end
  end

  assign rd_word    = stat_sel_q ? {count_q, 14'h0, ovf_q, new_q} : data_q;
  // Register bit 31 lands on Sl_DBus[0] (OPB big-endian bit numbering).
  assign Sl_DBus    = (ack && rnw_q) ? rd_word : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign dbg_state  = state_q;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2],
                       OPB_DBus[0:C_OPB_DWIDTH-3], OPB_DBus[C_OPB_DWIDTH-1],
                       |C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
module tb_opb_register_simulink2ppc;

  logic        OPB_Clk;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_valid;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [31:0] exp_q[$];

  opb_register_simulink2ppc dut (
    .OPB_Clk      (OPB_Clk),
    .OPB_Rst_n    (OPB_Rst_n),
    .OPB_ABus     (OPB_ABus),
    .OPB_BE       (OPB_BE),
    .OPB_DBus     (OPB_DBus),
    .OPB_RNW      (OPB_RNW),
    .OPB_select   (OPB_select),
    .OPB_seqAddr  (OPB_seqAddr),
    .Sl_DBus      (Sl_DBus),
    .Sl_xferAck   (Sl_xferAck),
    .Sl_errAck    (Sl_errAck),
    .Sl_retry     (Sl_retry),
    .Sl_toutSup   (Sl_toutSup),
    .user_data_in (user_data_in),
    .user_valid   (user_valid),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    OPB_Rst_n = 1'b0;
    OPB_select = 1'b0;
    OPB_RNW = 1'b0;
    OPB_ABus = '0;
    OPB_DBus = '0;
    OPB_BE = '0;
    user_valid = 1'b0;
    user_data_in = '0;
    repeat (2) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
  endtask

  // monitor: pops an expected read word on every acknowledge cycle
  always @(negedge OPB_Clk) begin
    if (Sl_xferAck === 1'b1) begin
      ack_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: Sl_DBus 0x%08h with no transfer pending", Sl_DBus);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (Sl_DBus !== e) begin
          errors++;
          $display("FAIL ack_data: got 0x%08h expected 0x%08h", Sl_DBus, e);
        end
      end
    end else if (OPB_Rst_n) begin
      checks++;
      if (Sl_DBus !== 32'h0) begin
        errors++;
        $display("FAIL idle_dbus: got 0x%08h expected 0x00000000", Sl_DBus);
      end
    end
  end

  task automatic capture(input logic [31:0] val);
    @(posedge OPB_Clk); #1;
    user_valid = 1'b1;
    user_data_in = val;
    @(posedge OPB_Clk); #1;
    user_valid = 1'b0;
  endtask

  // One OPB transfer: select held for 'hold' cycles; optional capture pulse
  // coincident with the acknowledge cycle.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp, input int n_ack,
                      input int hold, input logic cap_en, input logic [31:0] cap_val);
    int a0;
    @(posedge OPB_Clk); #1;
    if (n_ack > 0) exp_q.push_back(rnw ? exp : 32'h0);
    a0 = ack_cnt;
    OPB_select = 1'b1;
    OPB_ABus = addr;
    OPB_RNW = rnw;
    OPB_DBus = wdata;
    OPB_BE = be;
    @(posedge OPB_Clk); #1;
    if (cap_en) begin
      user_valid = 1'b1;
      user_data_in = cap_val;
    end
    @(posedge OPB_Clk); #1;
    user_valid = 1'b0;
    for (int i = 2; i < hold; i++) begin
      @(posedge OPB_Clk); #1;
    end
    OPB_select = 1'b0;
    OPB_RNW = 1'b0;
    OPB_ABus = '0;
    OPB_DBus = '0;
    OPB_BE = '0;
    @(posedge OPB_Clk); #1;
    @(posedge OPB_Clk); #1;
    chk("ack_count", ack_cnt - a0, n_ack);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    xfer(1'b1, addr, 32'h0, 4'h0, exp, 1, 2, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    xfer(1'b0, addr, wdata, be, 32'h0, 1, 2, 1'b0, 32'h0);
  endtask

  initial begin
    OPB_seqAddr = 1'b0;

    // reset state and reads of a fresh block
    do_reset();
    #1;
    chk("reset_ack", {31'h0, Sl_xferAck}, 32'h0);
    chk("reset_dbus", Sl_DBus, 32'h0);
    chk("reset_state", {30'h0, dbg_state}, 32'h0);
    chk("tie_offs", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    rd(32'h0, 32'h00000000);
    rd(32'h4, 32'h00000000);

    // single capture, DATA then STATUS
    capture(32'hDEADBEEF);
    rd(32'h0, 32'hDEADBEEF);
    rd(32'h4, 32'h00010000);

    // overflow, ignored clear (wrong lane), real clear, DATA writes ignored
    do_reset();
    capture(32'h1);
    capture(32'h2);
    rd(32'h4, 32'h00020003);
    wr(32'h4, 32'h00000002, 4'b1110);
    rd(32'h4, 32'h00020003);
    wr(32'h4, 32'h00000002, 4'b0001);
    rd(32'h4, 32'h00020001);
    wr(32'h0, 32'h12345678, 4'b1111);
    rd(32'h0, 32'h00000002);
    rd(32'h4, 32'h00020000);

    // capture coincident with DATA read acknowledge
    do_reset();
    capture(32'hAAAA0001);
    xfer(1'b1, 32'h0, 32'h0, 4'h0, 32'hAAAA0001, 1, 2, 1'b1, 32'h55550002);
    rd(32'h4, 32'h00020003);
    rd(32'h0, 32'h55550002);
    rd(32'h4, 32'h00020002);
    // aliased STATUS address and an out-of-window address
    rd(32'hF4, 32'h00020002);
    xfer(1'b1, 32'h100, 32'h0, 4'h0, 32'h0, 0, 2, 1'b0, 32'h0);

    // count wrap after 65536 captures, long select still one ack
    do_reset();
    @(posedge OPB_Clk); #1;
    user_valid = 1'b1;
    user_data_in = 32'h0000CAFE;
    repeat (65536) @(posedge OPB_Clk);
    #1;
    user_valid = 1'b0;
    xfer(1'b1, 32'h4, 32'h0, 4'h0, 32'h00000003, 1, 5, 1'b0, 32'h0);
    rd(32'h0, 32'h0000CAFE);

    // reset asserted during the acknowledge cycle
    capture(32'h00000077);
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b1;
    OPB_ABus = 32'h0;
    OPB_RNW = 1'b1;
    @(posedge OPB_Clk); #1;
    chk("ack_before_reset", {31'h0, Sl_xferAck}, 32'h1);
    #1;
    OPB_Rst_n = 1'b0;
    #1;
    chk("ack_in_reset", {31'h0, Sl_xferAck}, 32'h0);
    chk("dbus_in_reset", Sl_DBus, 32'h0);
    chk("state_in_reset", {30'h0, dbg_state}, 32'h0);
    OPB_select = 1'b0;
    OPB_RNW = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    rd(32'h0, 32'h00000000);
    rd(32'h4, 32'h00000000);

    repeat (3) @(posedge OPB_Clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
